counter_seq_ctrl: RTL and testbench

- Sequencer that shares one cascaded 74x169-style up/down counter (e.g. stack pointer or address counter) between three request sources: load, increment and decrement.
- Drives the counter's active-low load, active-low enables, direction and parallel data.
- Enforces limits and terminal count, and waits a programmable number of cycles for ripple-carry settling.
- Answers each requester with a 4-phase req/ack handshake.

---
 rtl/ttl_ctrl_pkg.sv | 26 ++
 rtl/settle_timer.sv | 34 +++
 rtl/counter_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_ctrl_pkg.sv
// ttl_ctrl_pkg
//   Shared types and constants for controllers that drive discrete
//   74-series TTL parts (counters, registers) over active-low strobes.
//   - state_t : sequencer state encoding
//   - op_t    : operation selected by a request arbiter
//   - ACTIVE_LOW_ON / ACTIVE_LOW_OFF : asserted / idle level of a _n pin
package ttl_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_SETTLE,
    S_ACK
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_t;

  localparam logic ACTIVE_LOW_ON  = 1'b0;
  localparam logic ACTIVE_LOW_OFF = 1'b1;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   4-bit down-counter used to wait for ripple-carry / bus settling after
//   a strobe to a TTL part.
//   Ports:
//     clock  in   system clock, rising edge
//     reset  in   synchronous, active-high; clears the count
//     start  in   load the count with len
//     len    in   4-bit count loaded on start
//     done   out  high while the count is zero
//   After a start with len = N, done goes high N cycles later and stays
//   high until the next start.
module settle_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] len,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= len;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Arbitrates load / increment / decrement requests onto one cascaded
//   74x169-style up/down counter. Checks limits and terminal count before
//   touching the counter, pulses exactly one strobe per accepted request,
//   waits SETTLE cycles for ripple carry, then answers with a 4-phase ack.
//   Parameters:
//     WIDTH    counter width in bits (multiple of 4)
//     LIMIT_HI highest legal value; increment refused here
//     LIMIT_LO lowest legal value; decrement refused here
//     SETTLE   settle cycles after the update (0..15)
//   Ports:
//     clock, reset              clock, synchronous active-high reset
//     load_req, load_val        parallel-load request and value
//     inc_req, dec_req          count up / count down requests
//     ack, err, busy            handshake ack, refusal flag, not-idle
//     cnt_q, cnt_rco_n          counter value and ripple-carry-out (low = TC)
//     cnt_load_n, cnt_ud        counter load strobe, direction (1 = up)
//     cnt_ent_n, cnt_enp_n      counter enables, active low
//     cnt_d                     counter parallel data
module counter_seq_ctrl
  import ttl_ctrl_pkg::*;
#(
  parameter int unsigned         WIDTH    = 8,
  parameter logic [WIDTH-1:0]    LIMIT_HI = '1,
  parameter logic [WIDTH-1:0]    LIMIT_LO = '0,
  parameter int unsigned         SETTLE   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_req,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc_req,
  input  logic             dec_req,
  output logic             ack,
  output logic             err,
  output logic             busy,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_rco_n,
  output logic             cnt_load_n,
  output logic             cnt_ud,
  output logic             cnt_ent_n,
  output logic             cnt_enp_n,
  output logic [WIDTH-1:0] cnt_d
);

  // The timer reports done N cycles after start with len = N; starting it
  // on the ISSUE cycle with SETTLE-1 makes the SETTLE state last exactly
  // SETTLE cycles.
  localparam logic [3:0] SETTLE_LEN = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t state;
  op_t    op;
  logic   illegal;
  logic   win_req;
  logic   timer_start;
  logic   timer_done;

  settle_timer u_settle_timer (
    .clock (clock),
    .reset (reset),
    .start (timer_start),
    .len   (SETTLE_LEN),
    .done  (timer_done)
  );

  assign timer_start = (state == S_ISSUE);

  // Legality is judged in SETUP, one cycle after cnt_ud changed, so
  // cnt_rco_n already reflects the direction of the pending count.
  // For a load, cnt_d holds the value latched at acceptance.
  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_INC:  illegal = (cnt_q >= LIMIT_HI) || (cnt_rco_n == ACTIVE_LOW_ON);
      OP_DEC:  illegal = (cnt_q <= LIMIT_LO) || (cnt_rco_n == ACTIVE_LOW_ON);
      OP_LOAD: illegal = (cnt_d < LIMIT_LO) || (cnt_d > LIMIT_HI);
      default: illegal = 1'b1;
    endcase
  end

  // Only the request that won arbitration releases the ack.
  always_comb begin
    win_req = 1'b0;
    case (op)
      OP_LOAD: win_req = load_req;
      OP_INC:  win_req = inc_req;
      OP_DEC:  win_req = dec_req;
      default: win_req = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      op         <= OP_INC;
      ack        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      cnt_load_n <= ACTIVE_LOW_OFF;
      cnt_ent_n  <= ACTIVE_LOW_OFF;
      cnt_enp_n  <= ACTIVE_LOW_OFF;
      cnt_ud     <= 1'b1;
      cnt_d      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_req) begin
            op    <= OP_LOAD;
            cnt_d <= load_val;
            busy  <= 1'b1;
            state <= S_SETUP;
          end else if (dec_req) begin
            op     <= OP_DEC;
            cnt_ud <= 1'b0;
            busy   <= 1'b1;
            state  <= S_SETUP;
          end else if (inc_req) begin
            op     <= OP_INC;
            cnt_ud <= 1'b1;
            busy   <= 1'b1;
            state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (illegal) begin
            err   <= 1'b1;
            ack   <= 1'b1;
            state <= S_ACK;
          end else begin
            if (op == OP_LOAD) begin
              cnt_load_n <= ACTIVE_LOW_ON;
            end else begin
              cnt_ent_n <= ACTIVE_LOW_ON;
              cnt_enp_n <= ACTIVE_LOW_ON;
            end
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The counter takes its update on this edge; strobes end here.
          cnt_load_n <= ACTIVE_LOW_OFF;
          cnt_ent_n  <= ACTIVE_LOW_OFF;
          cnt_enp_n  <= ACTIVE_LOW_OFF;
          if (SETTLE == 0) begin
            ack   <= 1'b1;
            state <= S_ACK;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (timer_done) begin
            ack   <= 1'b1;
            state <= S_ACK;
          end
        end

        S_ACK: begin
          if (!win_req) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          cnt_load_n <= ACTIVE_LOW_OFF;
          cnt_ent_n  <= ACTIVE_LOW_OFF;
          cnt_enp_n  <= ACTIVE_LOW_OFF;
          ack        <= 1'b0;
          err        <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       inc_req = 1'b0;
  logic       dec_req = 1'b0;
  logic       ack, err, busy;
  logic [7:0] cnt_q = 8'h00;
  logic       cnt_rco_n;
  logic       cnt_load_n, cnt_ud, cnt_ent_n, cnt_enp_n;
  logic [7:0] cnt_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic       err;
    logic [7:0] q;
    int         cyc;
    int         loads;
    int         counts;
  } exp_t;

  exp_t sbq[$];

  counter_seq_ctrl #(
    .WIDTH    (8),
    .LIMIT_HI (8'hF0),
    .LIMIT_LO (8'h00),
    .SETTLE   (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_req   (load_req),
    .load_val   (load_val),
    .inc_req    (inc_req),
    .dec_req    (dec_req),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .cnt_q      (cnt_q),
    .cnt_rco_n  (cnt_rco_n),
    .cnt_load_n (cnt_load_n),
    .cnt_ud     (cnt_ud),
    .cnt_ent_n  (cnt_ent_n),
    .cnt_enp_n  (cnt_enp_n),
    .cnt_d      (cnt_d)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // 74x169 model: synchronous load beats counting; RCO low at terminal count.
  always @(posedge clock) begin
    if (!cnt_load_n) cnt_q <= cnt_d;
    else if (!cnt_ent_n && !cnt_enp_n) cnt_q <= cnt_ud ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  assign cnt_rco_n = cnt_ud ? (cnt_q != 8'hFF) : (cnt_q != 8'h00);

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic e, input logic [7:0] q, input int c, input int nl, input int nc);
    exp_t x;
    x.err = e; x.q = q; x.cyc = c; x.loads = nl; x.counts = nc;
    sbq.push_back(x);
  endtask

  task automatic wait_ack();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(1'b0, "ack_timeout", 0, 1);
  endtask

  // kind: 0 load, 1 inc, 2 dec. Request is held `hold` cycles past ack.
  task automatic run_op(input int kind, input logic [7:0] val, input logic eerr,
                        input logic [7:0] eq, input int hold);
    @(negedge clock);
    load_val = val;
    load_req = (kind == 0);
    inc_req  = (kind == 1);
    dec_req  = (kind == 2);
    push(eerr, eq, cyc + (eerr ? 2 : 4),
         (kind == 0 && !eerr) ? 1 : 0, (kind != 0 && !eerr) ? 1 : 0);
    wait_ack();
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk(ack == 1'b1, "ack_hold", ack, 1);
    end
    load_req = 1'b0;
    inc_req  = 1'b0;
    dec_req  = 1'b0;
    @(negedge clock);
    chk(ack == 1'b0, "ack_clear", ack, 0);
    chk(busy == 1'b0, "busy_clear", busy, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(ack == 1'b0,        {tag, "_ack"},    ack, 0);
    chk(err == 1'b0,        {tag, "_err"},    err, 0);
    chk(busy == 1'b0,       {tag, "_busy"},   busy, 0);
    chk(cnt_load_n == 1'b1, {tag, "_load_n"}, cnt_load_n, 1);
    chk(cnt_ent_n == 1'b1,  {tag, "_ent_n"},  cnt_ent_n, 1);
    chk(cnt_enp_n == 1'b1,  {tag, "_enp_n"},  cnt_enp_n, 1);
    chk(cnt_ud == 1'b1,     {tag, "_ud"},     cnt_ud, 1);
    chk(cnt_d == 8'h00,     {tag, "_d"},      cnt_d, 0);
  endtask

  initial begin
    fork
      begin : monitor
        int   nl;
        int   nc;
        logic ack_prev;
        exp_t e;
        nl = 0; nc = 0; ack_prev = 1'b0;
        forever begin
          @(negedge clock);
          if (reset) begin
            nl = 0; nc = 0; ack_prev = 1'b0;
          end else begin
            if (!cnt_load_n || !cnt_ent_n || !cnt_enp_n) begin
              chk(!(!cnt_load_n && (!cnt_ent_n || !cnt_enp_n)), "strobe_overlap",
                  {cnt_load_n, cnt_ent_n, cnt_enp_n}, 3'b011);
              chk(cnt_ent_n == cnt_enp_n, "enable_pair", {cnt_ent_n, cnt_enp_n}, 2'b00);
            end
            if (!cnt_load_n) nl++;
            if (!cnt_ent_n && !cnt_enp_n) nc++;
            if (ack && !ack_prev) begin
              if (sbq.size() == 0) begin
                chk(1'b0, "unexpected_ack", 1, 0);
              end else begin
                e = sbq.pop_front();
                chk(err == e.err,   "sb_err",        err, e.err);
                chk(cnt_q == e.q,   "sb_q",          cnt_q, e.q);
                chk(cyc == e.cyc,   "sb_ack_cycle",  cyc, e.cyc);
                chk(nl == e.loads,  "sb_load_pulse", nl, e.loads);
                chk(nc == e.counts, "sb_cnt_pulse",  nc, e.counts);
              end
              nl = 0; nc = 0;
            end
            ack_prev = ack;
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Preload 0x10, then increment to 0x11
    run_op(0, 8'h10, 1'b0, 8'h10, 0);
    run_op(1, 8'h00, 1'b0, 8'h11, 0);

    // Load and inc together: load wins, inc follows once load_req drops
    @(negedge clock);
    load_val = 8'h80;
    load_req = 1'b1;
    inc_req  = 1'b1;
    push(1'b0, 8'h80, cyc + 4, 1, 0);
    wait_ack();
    load_req = 1'b0;
    push(1'b0, 8'h81, cyc + 5, 0, 1);
    wait_ack();
    inc_req = 1'b0;
    @(negedge clock);
    chk(ack == 1'b0, "ack_clear_inc2", ack, 0);

    // Increment at LIMIT_HI refused; out-of-range load refused
    run_op(0, 8'hF0, 1'b0, 8'hF0, 0);
    run_op(1, 8'h00, 1'b1, 8'hF0, 0);
    run_op(0, 8'hF8, 1'b1, 8'hF0, 0);

    // Decrement at 0 refused, no wrap
    run_op(0, 8'h00, 1'b0, 8'h00, 0);
    run_op(2, 8'h00, 1'b1, 8'h00, 0);

    // Reset during SETTLE of a decrement from 0x06
    run_op(0, 8'h06, 1'b0, 8'h06, 0);
    @(negedge clock);
    dec_req = 1'b1;
    repeat (3) @(negedge clock);
    chk(busy == 1'b1, "busy_in_settle", busy, 1);
    reset   = 1'b1;
    dec_req = 1'b0;
    @(negedge clock);
    chk_idle_outputs("midreset");
    chk(cnt_q == 8'h05, "q_after_abort", cnt_q, 8'h05);
    reset = 1'b0;
    run_op(2, 8'h00, 1'b0, 8'h04, 0);

    // Request held across ack: one increment only
    run_op(1, 8'h00, 1'b0, 8'h05, 5);
    chk(cnt_q == 8'h05, "q_after_hold", cnt_q, 8'h05);

    // Request dropped before ack: still completes, single-cycle ack
    @(negedge clock);
    inc_req = 1'b1;
    push(1'b0, 8'h06, cyc + 4, 0, 1);
    @(negedge clock);
    inc_req = 1'b0;
    wait_ack();
    @(negedge clock);
    chk(ack == 1'b0, "ack_single", ack, 0);

    repeat (3) @(negedge clock);
    chk(sbq.size() == 0, "sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
